// File: rtl/cpu_sequencer_if.sv
// Fetch/decode/execute control bundle between the sequencer and the datapath/instruction memory.
interface cpu_sequencer_if;
    logic       imem_req;
    logic       imem_ack;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [5:0] op;
    logic       branch_taken;

    modport master (
        output imem_req, ir_we, pc_we, pc_sel, rf_we,
        input  imem_ack, op, branch_taken
    );

    modport slave (
        input  imem_req, ir_we, pc_we, pc_sel, rf_we,
        output imem_ack, op, branch_taken
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> WB with fetch timeout,
// illegal-opcode halt, single-step mode and a retired-instruction counter.
module cpu_sequencer (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   step,
    input  logic                   clear,
    cpu_sequencer_if.master        bus,
    output logic [2:0]             state,
    output logic                   halted,
    output logic [1:0]             err,
    output logic [31:0]            retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_WB     = 3'b100,
        S_HALT   = 3'b101
    } state_t;

    state_t      cur;
    logic        step_mode;
    logic        armed;
    logic [7:0]  wait_cnt;
    logic [31:0] retired_q;

    function automatic logic op_legal(input logic [5:0] o);
        return (o[5:3] == 3'b000) || (o[5:3] == 3'b001) ||
               (o == 6'b011100) || (o == 6'b011111);
    endfunction

    function automatic logic op_writes_rf(input logic [5:0] o);
        return (o == 6'b000000) || (o[5:3] == 3'b001) ||
               (o == 6'b011100) || (o == 6'b011111);
    endfunction

    assign state   = cur;
    assign retired = retired_q;
    assign halted  = (cur == S_HALT);

    // PC source is only meaningful while pc_we is high, i.e. in EXEC.
    always_comb begin
        bus.pc_sel = 2'b00;
        if (cur == S_EXEC) begin
            if (bus.op[5:1] == 5'b00001)
                bus.pc_sel = 2'b10;
            else if (bus.branch_taken &&
                     ((bus.op == 6'b000001) || (bus.op[5:2] == 4'b0001)))
                bus.pc_sel = 2'b01;
        end
    end

    // Strobes are registered together with the transition that enters their state,
    // so each one is high exactly for the duration of that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur          <= S_IDLE;
            step_mode    <= 1'b0;
            armed        <= 1'b0;
            wait_cnt     <= '0;
            retired_q    <= '0;
            err          <= 2'b00;
            bus.imem_req <= 1'b0;
            bus.ir_we    <= 1'b0;
            bus.pc_we    <= 1'b0;
            bus.rf_we    <= 1'b0;
        end else begin
            armed        <= 1'b1;
            bus.imem_req <= 1'b0;
            bus.ir_we    <= 1'b0;
            bus.pc_we    <= 1'b0;
            bus.rf_we    <= 1'b0;
            case (cur)
                S_IDLE: begin
                    if (armed && (run || step)) begin
                        cur          <= S_FETCH;
                        step_mode    <= step & ~run;
                        wait_cnt     <= '0;
                        bus.imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        cur       <= S_DECODE;
                        bus.ir_we <= 1'b1;
                    end else if (wait_cnt == 8'd254) begin
                        cur      <= S_HALT;
                        wait_cnt <= 8'd255;
                        err      <= 2'b01;
                    end else begin
                        wait_cnt     <= wait_cnt + 8'd1;
                        bus.imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (op_legal(bus.op)) begin
                        cur       <= S_EXEC;
                        bus.pc_we <= 1'b1;
                    end else begin
                        cur <= S_HALT;
                        err <= 2'b10;
                    end
                end
                S_EXEC: begin
                    cur       <= S_WB;
                    bus.rf_we <= op_writes_rf(bus.op);
                end
                S_WB: begin
                    retired_q <= retired_q + 32'd1;
                    if (run && !step_mode) begin
                        cur          <= S_FETCH;
                        wait_cnt     <= '0;
                        bus.imem_req <= 1'b1;
                    end else begin
                        cur <= S_IDLE;
                    end
                end
                S_HALT: begin
                    if (clear) begin
                        cur <= S_IDLE;
                        err <= 2'b00;
                    end
                end
                default: cur <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: run, step, timeout, illegal opcode, reset and counter wrap.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        step;
    logic        clear;
    logic [2:0]  state;
    logic        halted;
    logic [1:0]  err;
    logic [31:0] retired;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    cpu_sequencer_if bus ();

    cpu_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .step    (step),
        .clear   (clear),
        .bus     (bus),
        .state   (state),
        .halted  (halted),
        .err     (err),
        .retired (retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // strobes packed as {imem_req, ir_we, pc_we, rf_we}
    function automatic logic [31:0] strb();
        return {28'd0, bus.imem_req, bus.ir_we, bus.pc_we, bus.rf_we};
    endfunction

    initial begin
        int unsigned n;
        int unsigned reqn;

        rst_n = 1'b0; run = 1'b0; step = 1'b0; clear = 1'b0;
        bus.imem_ack = 1'b0; bus.op = 6'b000000; bus.branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_strobes", strb(), 32'h0);
        chk("rst_pc_sel", 32'(bus.pc_sel), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_retired", retired, 32'd0);

        // continuous run, zero-wait ack
        rst_n = 1'b1; run = 1'b1; bus.imem_ack = 1'b1;
        tick(); chk("first_edge_idle", 32'(state), 32'd0);
        tick(); chk("run_fetch", 32'(state), 32'd1); chk("run_fetch_strb", strb(), 32'h8);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("run_decode", 32'(state), 32'd2); chk("run_decode_strb", strb(), 32'h4);
            tick(); chk("run_exec", 32'(state), 32'd3); chk("run_exec_strb", strb(), 32'h2);
            chk("run_exec_pc_sel", 32'(bus.pc_sel), 32'd0);
            tick(); chk("run_wb", 32'(state), 32'd4); chk("run_wb_strb", strb(), 32'h1);
            tick(); chk("run_refetch", 32'(state), 32'd1); chk("run_refetch_strb", strb(), 32'h8);
        end
        chk("run_retired3", retired, 32'd3);

        // dropping run mid-instruction lets it complete
        run = 1'b0;
        tick(); chk("drop_decode", 32'(state), 32'd2);
        tick(); tick(); chk("drop_wb", 32'(state), 32'd4);
        tick(); chk("drop_idle", 32'(state), 32'd0); chk("drop_retired", retired, 32'd4);
        chk("drop_idle_strb", strb(), 32'h0);

        // single step, taken branch
        bus.op = 6'b000100; bus.branch_taken = 1'b1; step = 1'b1;
        tick(); step = 1'b0; chk("step_fetch", 32'(state), 32'd1);
        tick(); chk("step_decode", 32'(state), 32'd2);
        tick(); chk("step_exec", 32'(state), 32'd3);
        chk("step_pc_sel", 32'(bus.pc_sel), 32'd1); chk("step_exec_strb", strb(), 32'h2);
        tick(); chk("step_wb_strb", strb(), 32'h0);
        tick(); chk("step_idle", 32'(state), 32'd0); chk("step_retired", retired, 32'd5);
        tick(); chk("step_stays_idle", 32'(state), 32'd0);

        // asynchronous reset during EXEC
        bus.op = 6'b000000; bus.branch_taken = 1'b0; run = 1'b1;
        tick(); tick(); tick();
        chk("pre_rst_exec", 32'(state), 32'd3); chk("pre_rst_retired", retired, 32'd5);
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_strb", strb(), 32'h0);
        chk("async_rst_retired", retired, 32'd0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick(); chk("post_rst_idle", 32'(state), 32'd0);

        // branch not taken
        bus.op = 6'b000001; step = 1'b1;
        tick(); step = 1'b0;
        tick(); tick(); chk("nt_pc_sel", 32'(bus.pc_sel), 32'd0);
        tick(); chk("nt_wb_strb", strb(), 32'h0);
        tick(); chk("nt_retired", retired, 32'd1);

        // illegal opcode
        bus.op = 6'b110000; step = 1'b1;
        tick(); step = 1'b0;
        tick(); tick();
        chk("ill_state", 32'(state), 32'd5); chk("ill_halted", 32'(halted), 32'd1);
        chk("ill_err", 32'(err), 32'd2); chk("ill_strb", strb(), 32'h0);
        run = 1'b1; step = 1'b1;
        tick(); chk("ill_ignores_run", 32'(state), 32'd5); chk("ill_hold_strb", strb(), 32'h0);
        run = 1'b0; step = 1'b0; clear = 1'b1;
        tick(); clear = 1'b0;
        chk("ill_clear_state", 32'(state), 32'd0); chk("ill_clear_err", 32'(err), 32'd0);
        chk("ill_clear_halted", 32'(halted), 32'd0); chk("ill_keeps_retired", retired, 32'd1);

        // fetch timeout
        bus.op = 6'b000000; bus.imem_ack = 1'b0; run = 1'b1;
        tick();
        n = 0; reqn = 0;
        while (state == 3'd1 && n < 300) begin
            n++;
            if (bus.imem_req) reqn++;
            tick();
        end
        run = 1'b0;
        chk("to_fetch_cycles", n, 32'd255); chk("to_req_cycles", reqn, 32'd255);
        chk("to_state", 32'(state), 32'd5); chk("to_err", 32'(err), 32'd1);
        chk("to_halted", 32'(halted), 32'd1); chk("to_strb", strb(), 32'h0);
        clear = 1'b1;
        tick(); clear = 1'b0;
        chk("to_clear_state", 32'(state), 32'd0); chk("to_clear_err", 32'(err), 32'd0);

        // ack on the last permissible fetch cycle wins over the timeout
        run = 1'b1;
        tick();
        repeat (254) tick();
        chk("prio_still_fetch", 32'(state), 32'd1);
        bus.imem_ack = 1'b1; run = 1'b0;
        tick(); chk("prio_decode", 32'(state), 32'd2); chk("prio_err", 32'(err), 32'd0);
        tick(); tick(); tick();
        chk("prio_idle", 32'(state), 32'd0); chk("prio_retired", retired, 32'd2);

        // jump with retired counter wrap
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        chk("wrap_preload", retired, 32'hFFFF_FFFF);
        @(negedge clk);
        bus.op = 6'b000010; step = 1'b1;
        tick(); step = 1'b0;
        tick(); tick();
        chk("jmp_pc_sel", 32'(bus.pc_sel), 32'd2); chk("jmp_exec_strb", strb(), 32'h2);
        tick(); chk("jmp_wb_strb", strb(), 32'h0);
        tick(); chk("jmp_idle", 32'(state), 32'd0); chk("wrap_retired", retired, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
